// File: rtl/if_stage.sv
// Instruction fetch stage: PC, imem request handshake, one-entry skid buffer and IF/ID register.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky misaligned-redirect flag that halts fetching.
module if_stage (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
`ifdef FETCH_MISALIGN_CHECK_EN
   ,output logic        fetch_misaligned
`endif
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'h0000_0004;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SKID  = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_q, req_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_instr_q, id_instr_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            halt_q, halt_d;
    logic [XLEN-1:0] redir_tgt;
    logic            redir_bad;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redir_tgt = redirect_pc;
    assign redir_bad = (redirect_pc[1:0] != 2'b00);
    assign fetch_misaligned = halt_q;
`else
    assign redir_tgt = redirect_pc & ~32'h0000_0003;
    assign redir_bad = 1'b0;
`endif

    // Next-state, PC, skid and IF/ID update; redirect overrides everything else.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        halt_d       = halt_q;

        case (state_q)
            S_IDLE: begin
                if (!halt_q) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    if (!stall) begin
                        id_valid_d = 1'b1;
                        id_pc_d    = fetch_pc_q;
                        id_instr_d = imem_rdata;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = fetch_pc_q;
                        state_d      = S_SKID;
                    end
                end else if (!stall) begin
                    id_valid_d = 1'b0;
                end
            end
            S_SKID: begin
                if (!stall) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = skid_pc_q;
                    id_instr_d = skid_instr_q;
                    state_d    = S_FETCH;
                end
            end
            default: begin
                if (imem_ready) state_d = halt_q ? S_IDLE : S_FETCH;
            end
        endcase

        if (redirect) begin
            id_valid_d   = 1'b0;
            id_instr_d   = NOP_INSTR;
            skid_instr_d = NOP_INSTR;
            skid_pc_d    = '0;
            fetch_pc_d   = redir_tgt;
            halt_d       = halt_q | redir_bad;
            // An in-flight request must still complete before the target is fetched.
            if ((state_q == S_FETCH || state_q == S_DROP) && !imem_ready) begin
                state_d = S_DROP;
            end else begin
                state_d = halt_d ? S_IDLE : S_FETCH;
            end
        end
    end

    // Request address is held through DROP so the outstanding handshake stays stable.
    always_comb begin
        req_d  = (state_d == S_FETCH) || (state_d == S_DROP);
        addr_d = (state_d == S_DROP) ? addr_q : fetch_pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b0;
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_instr_q   <= NOP_INSTR;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            halt_q       <= halt_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_instr  = id_instr_q;

    assign opcode = id_instr_q[6:0];
    assign rd     = id_instr_q[11:7];
    assign funct3 = id_instr_q[14:12];
    assign rs1    = id_instr_q[19:15];
    assign rs2    = id_instr_q[24:20];
    assign funct7 = id_instr_q[31:25];

endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage plus hand sequences for wrap, misaligned redirect and reset.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    if_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2)
`ifdef FETCH_MISALIGN_CHECK_EN
       ,.fetch_misaligned(fetch_misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        ready;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    localparam int NV = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0   = 32'h0020_8133;
    localparam logic [31:0] W4   = 32'h0041_01B3;
    localparam logic [31:0] W8   = 32'h0062_0233;
    localparam logic [31:0] WC   = 32'h0083_02B3;
    localparam logic [31:0] W100 = 32'h0000_0513;
    localparam logic [31:0] W200 = 32'h00A0_0593;

    vec_t vecs [NV];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic st, input logic rd_i, input logic [31:0] rpc,
                                input logic rdy, input logic [31:0] rdata,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic evalid, input logic [31:0] epc,
                                input logic [31:0] einstr);
        vec_t v;
        v.stall = st; v.redirect = rd_i; v.rpc = rpc; v.ready = rdy; v.rdata = rdata;
        v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = evalid;
        v.exp_pc = epc; v.exp_instr = einstr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rd_i, input logic [31:0] rpc,
                         input logic rdy, input logic [31:0] rdata);
        stall = st; redirect = rd_i; redirect_pc = rpc; imem_ready = rdy; imem_rdata = rdata;
    endtask

    initial begin
        // stall, redirect, rpc, ready, rdata | req, addr, valid, pc, instr (outputs in that cycle)
        vecs[0]  = mk(0, 0, 32'h0,   0, 32'h0,        0, 32'h0,   0, 32'h0,   NOP);
        vecs[1]  = mk(0, 0, 32'h0,   1, W0,           1, 32'h0,   0, 32'h0,   NOP);
        vecs[2]  = mk(0, 0, 32'h0,   1, W4,           1, 32'h4,   1, 32'h0,   W0);
        vecs[3]  = mk(1, 0, 32'h0,   1, W8,           1, 32'h8,   1, 32'h4,   W4);
        vecs[4]  = mk(1, 0, 32'h0,   0, 32'h0,        0, 32'hC,   1, 32'h4,   W4);
        vecs[5]  = mk(0, 0, 32'h0,   0, 32'h0,        0, 32'hC,   1, 32'h4,   W4);
        vecs[6]  = mk(0, 0, 32'h0,   1, WC,           1, 32'hC,   1, 32'h8,   W8);
        vecs[7]  = mk(0, 0, 32'h0,   0, 32'h0,        1, 32'h10,  1, 32'hC,   WC);
        vecs[8]  = mk(0, 1, 32'h100, 0, 32'h0,        1, 32'h10,  0, 32'hC,   WC);
        vecs[9]  = mk(0, 0, 32'h0,   0, 32'h0,        1, 32'h10,  0, 32'hC,   NOP);
        vecs[10] = mk(0, 0, 32'h0,   1, 32'hDEADBEEF, 1, 32'h10,  0, 32'hC,   NOP);
        vecs[11] = mk(0, 0, 32'h0,   1, W100,         1, 32'h100, 0, 32'hC,   NOP);
        vecs[12] = mk(1, 1, 32'h200, 1, 32'hBAD0BAD0, 1, 32'h104, 1, 32'h100, W100);
        vecs[13] = mk(0, 0, 32'h0,   1, W200,         1, 32'h200, 0, 32'h100, NOP);
        vecs[14] = mk(0, 0, 32'h0,   0, 32'h0,        1, 32'h204, 1, 32'h200, W200);
        vecs[15] = mk(0, 0, 32'h0,   0, 32'h0,        1, 32'h204, 0, 32'h200, W200);

        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(id_valid), 32'h0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_instr", id_instr, NOP);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            if (i > 0) @(negedge clk);
            drive(vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].ready, vecs[i].rdata);
            #1;
            check($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_valid", i), 32'(id_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_pc", i), id_pc, vecs[i].exp_pc);
            check($sformatf("v%0d_instr", i), id_instr, vecs[i].exp_instr);
            if (i == 2) begin
                check("dec_opcode", 32'(opcode), 32'h33);
                check("dec_funct3", 32'(funct3), 32'h0);
                check("dec_funct7", 32'(funct7), 32'h0);
                check("dec_rd", 32'(rd), 32'd2);
                check("dec_rs1", 32'(rs1), 32'd1);
                check("dec_rs2", 32'(rs2), 32'd2);
            end
            if (i == 14) begin
                check("dec_w200_rd", 32'(rd), 32'd11);
                check("dec_w200_rs2", 32'(rs2), 32'd10);
            end
        end

        // Redirect to the top word, then confirm the PC wraps to zero.
        @(negedge clk);
        drive(0, 1, 32'hFFFF_FFFC, 1, 32'h1111_1111);
        @(negedge clk);
        drive(0, 0, 32'h0, 1, 32'h0000_0093);
        #1;
        check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        check("wrap_valid0", 32'(id_valid), 32'h0);
        @(negedge clk);
        drive(0, 1, 32'h0000_0102, 0, 32'h0);
        #1;
        check("wrap_addr0", imem_addr, 32'h0);
        check("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_instr", id_instr, 32'h0000_0093);

        // Misaligned redirect while a request is outstanding: drop completes first.
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 32'h0);
        #1;
        check("mis_drop_req", 32'(imem_req), 32'h1);
        check("mis_drop_addr", imem_addr, 32'h0);
        check("mis_drop_valid", 32'(id_valid), 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 1, 32'h2222_2222);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 32'h0);
        #1;
        check("mis_valid", 32'(id_valid), 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_flag", 32'(fetch_misaligned), 32'h1);
        check("mis_req_off", 32'(imem_req), 32'h0);
        repeat (3) @(negedge clk);
        #1;
        check("mis_req_halted", 32'(imem_req), 32'h0);
        check("mis_flag_sticky", 32'(fetch_misaligned), 32'h1);
`else
        check("mis_req_on", 32'(imem_req), 32'h1);
        check("mis_addr_aligned", imem_addr, 32'h100);
`endif

        // Asynchronous reset in the middle of operation.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_req", 32'(imem_req), 32'h0);
        check("mrst_addr", imem_addr, 32'h0);
        check("mrst_valid", 32'(id_valid), 32'h0);
        check("mrst_instr", id_instr, NOP);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mrst_flag", 32'(fetch_misaligned), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_req", 32'(imem_req), 32'h1);
        check("post_rst_addr", imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
